// File: rtl/fe_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fe_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0033;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fe_state_e;

endpackage

// File: rtl/fe_tgt.sv
// Redirect target select (branch > jal > jalr) with word alignment and misalignment flag.
module fe_tgt (
  input  logic [31:0] pc,
  input  logic        hold,
  input  logic        dec_jal,
  input  logic        dec_jalr,
  input  logic [31:0] dec_imm,
  input  logic [31:0] dec_rs1,
  input  logic        br_taken,
  input  logic [31:0] br_tgt,
  output logic        redir,
  output logic [31:0] tgt,
  output logic        misalign
);

  logic [31:0] raw;

  // Branch comes from an older instruction, so it outranks decode jumps;
  // decode jumps wait out a hold because rs1 may not be forwarded yet.
  always_comb begin
    raw   = '0;
    redir = 1'b0;
    if (br_taken) begin
      raw   = br_tgt;
      redir = 1'b1;
    end else if (!hold && dec_jal) begin
      raw   = pc + dec_imm;
      redir = 1'b1;
    end else if (!hold && dec_jalr) begin
      raw   = (dec_rs1 + dec_imm) & ~32'h1;
      redir = 1'b1;
    end
  end

  assign misalign = redir & (raw[1:0] != 2'b00);
  assign tgt      = {raw[31:2], 2'b00};

endmodule

// File: rtl/fe_stage.sv
// Fetch stage: owns the PC, drives the 1-cycle imem, buffers across decode holds, applies redirects.
// Build option FE_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and sets sticky o_misalign.
module fe_stage
  import fe_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_hold,
  input  logic        i_dec_jal,
  input  logic        i_dec_jalr,
  input  logic [31:0] i_dec_imm,
  input  logic [31:0] i_dec_rs1,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_tgt,
  input  logic        i_halt,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_vld,
  output logic        o_misalign
);

`ifdef FE_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  fe_state_e   state, state_nxt;
  logic [31:0] f_pc, f_pc_nxt;
  logic [31:0] d_pc, d_pc_nxt;
  logic [31:0] inst_buf, inst_buf_nxt;
  logic        d_vld, d_vld_nxt;
  logic        buf_vld, buf_vld_nxt;
  logic        mis_q, mis_nxt;
  logic        redir, tgt_mis;
  logic [31:0] tgt;

  fe_tgt u_tgt (
    .pc       (d_pc),
    .hold     (i_hold),
    .dec_jal  (i_dec_jal),
    .dec_jalr (i_dec_jalr),
    .dec_imm  (i_dec_imm),
    .dec_rs1  (i_dec_rs1),
    .br_taken (i_br_taken),
    .br_tgt   (i_br_tgt),
    .redir    (redir),
    .tgt      (tgt),
    .misalign (tgt_mis)
  );

  always_comb begin
    state_nxt    = state;
    f_pc_nxt     = f_pc;
    d_pc_nxt     = d_pc;
    d_vld_nxt    = d_vld;
    inst_buf_nxt = inst_buf;
    buf_vld_nxt  = buf_vld;
    mis_nxt      = mis_q;
    if (state == ST_HALT || i_halt) begin
      state_nxt = ST_HALT;
    end else if (redir && TRAP_EN && tgt_mis) begin
      mis_nxt   = 1'b1;
      d_vld_nxt = 1'b0;
      state_nxt = ST_HALT;
    end else if (redir) begin
      // Killing d_vld drops the read already in flight: exactly one bubble.
      f_pc_nxt    = tgt;
      d_vld_nxt   = 1'b0;
      buf_vld_nxt = 1'b0;
      state_nxt   = ST_RUN;
    end else if (i_hold && state != ST_BOOT) begin
      // imem keeps reading f_pc during the hold, so capture d_pc's word once.
      if (state == ST_RUN) begin
        inst_buf_nxt = i_imem_rdata;
        buf_vld_nxt  = 1'b1;
        state_nxt    = ST_HOLD;
      end
    end else begin
      d_pc_nxt    = f_pc;
      d_vld_nxt   = 1'b1;
      f_pc_nxt    = f_pc + PC_INC;
      buf_vld_nxt = 1'b0;
      state_nxt   = ST_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_BOOT;
      f_pc     <= RESET_ADDR;
      d_pc     <= RESET_ADDR;
      d_vld    <= 1'b0;
      inst_buf <= NOP;
      buf_vld  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      f_pc     <= f_pc_nxt;
      d_pc     <= d_pc_nxt;
      d_vld    <= d_vld_nxt;
      inst_buf <= inst_buf_nxt;
      buf_vld  <= buf_vld_nxt;
      mis_q    <= mis_nxt;
    end
  end

  assign o_imem_raddr = f_pc;
  assign o_inst       = buf_vld ? inst_buf : i_imem_rdata;
  assign o_pc         = d_pc;
  assign o_nxt_pc     = d_pc + PC_INC;
  assign o_vld        = d_vld & (state != ST_HALT);
  assign o_misalign   = TRAP_EN & mis_q;

endmodule

// File: tb/tb_fe_stage.sv
// Scoreboard bench for fe_stage: a PC-stream model predicts each cycle; a negedge monitor compares.
module tb_fe_stage;

  localparam logic [31:0] RST_A = 32'h0000_0100;
`ifdef FE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_hold, i_dec_jal, i_dec_jalr, i_br_taken, i_halt;
  logic [31:0] i_dec_imm, i_dec_rs1, i_br_tgt;
  logic [31:0] o_imem_raddr, o_inst, o_pc, o_nxt_pc;
  logic [31:0] i_imem_rdata = '0;
  logic        o_vld, o_misalign;

  always #5 i_clk = ~i_clk;

  fe_stage #(.RESET_ADDR(RST_A)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_imem_raddr(o_imem_raddr), .i_imem_rdata(i_imem_rdata),
    .i_hold(i_hold), .i_dec_jal(i_dec_jal), .i_dec_jalr(i_dec_jalr), .i_dec_imm(i_dec_imm),
    .i_dec_rs1(i_dec_rs1), .i_br_taken(i_br_taken), .i_br_tgt(i_br_tgt), .i_halt(i_halt),
    .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_vld(o_vld), .o_misalign(o_misalign)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge i_clk) i_imem_rdata <= memf(o_imem_raddr);

  typedef struct {
    bit          chk;
    bit          vld;
    logic [31:0] pc;
    logic [31:0] raddr;
    bit          mis;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: m_pc is the next pc decode will see; m_bub marks one pending bubble.
  logic [31:0] m_pc = RST_A;
  logic [31:0] m_hraddr = '0;
  bit          m_bub = 1'b1, m_halt = 1'b0, m_mis = 1'b0, m_known = 1'b0;

  function automatic bit cur_vld();
    return !m_halt && !m_bub;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        cmp("vld", {31'd0, o_vld}, {31'd0, e.vld});
        cmp("raddr", o_imem_raddr, e.raddr);
        cmp("misalign", {31'd0, o_misalign}, {31'd0, e.mis});
        if (e.vld) begin
          cmp("pc", o_pc, e.pc);
          cmp("nxt_pc", o_nxt_pc, e.pc + 32'd4);
          cmp("inst", o_inst, memf(e.pc));
        end
      end
    end
  end

  task automatic step(input bit rst, hold, jal, jalr, br, halt,
                      input logic [31:0] imm, rs1, btgt);
    exp_t        e;
    logic [31:0] t;
    i_rst = rst; i_hold = hold; i_dec_jal = jal; i_dec_jalr = jalr;
    i_br_taken = br; i_halt = halt; i_dec_imm = imm; i_dec_rs1 = rs1; i_br_tgt = btgt;
    e.chk   = m_known;
    e.vld   = cur_vld();
    e.pc    = m_pc;
    e.raddr = m_halt ? m_hraddr : (m_bub ? m_pc : m_pc + 32'd4);
    e.mis   = m_mis;
    q.push_back(e);
    t = '0;
    if (br) t = btgt;
    else if (jal) t = m_pc + imm;
    else if (jalr) t = (rs1 + imm) & ~32'h1;
    if (rst) begin
      m_pc = RST_A; m_bub = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_known = 1'b1;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (halt) begin
      m_halt = 1'b1; m_hraddr = e.raddr;
    end else if (br || ((jal || jalr) && !hold)) begin
      if (TRAP && t[1:0] != 2'b00) begin
        m_halt = 1'b1; m_mis = 1'b1; m_hraddr = e.raddr;
      end else begin
        m_pc = {t[31:2], 2'b00}; m_bub = 1'b1;
      end
    end else if (hold) begin
      m_bub = m_bub;
    end else if (m_bub) begin
      m_bub = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic run_to(input logic [31:0] pc);
    for (int k = 0; k < 40 && !(cur_vld() && m_pc == pc); k++) idle();
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    step(1, 0, 0, 0, 0, 0, '0, '0, '0);
    step(1, 0, 0, 0, 0, 0, '0, '0, '0);
    run_to(32'h108);
    repeat (3) step(0, 1, 0, 0, 0, 0, '0, '0, '0);
    run_to(32'h110);
    step(0, 0, 1, 0, 0, 0, 32'h20, '0, '0);
    repeat (3) idle();
    step(0, 1, 0, 1, 1, 0, 32'h40, 32'h1000, 32'h200);
    repeat (3) idle();
    step(0, 0, 0, 1, 0, 0, 32'h0, 32'h301, '0);
    repeat (3) idle();
    if (TRAP) begin
      step(0, 0, 0, 1, 0, 0, 32'h0, 32'h302, '0);
      repeat (4) idle();
      step(1, 0, 0, 0, 0, 0, '0, '0, '0);
      repeat (3) idle();
    end
    for (int n = 0; n < 1500; n++) begin
      bit          h, j, jr, b;
      int          r;
      logic [31:0] im, r1, bt;
      im = $urandom(); r1 = $urandom(); bt = $urandom();
      if (TRAP) begin
        im[1:0] = 2'b00; r1[1:0] = 2'b00; bt[1:0] = 2'b00;
      end
      r = $urandom_range(0, 99);
      h = 1'b0; j = 1'b0; jr = 1'b0; b = 1'b0;
      if (cur_vld()) begin
        h  = ($urandom_range(0, 4) == 0);
        b  = (r < 8);
        j  = (r >= 8 && r < 14);
        jr = (r >= 14 && r < 20);
      end else begin
        b = (r < 10);
      end
      step(0, h, j, jr, b, 0, im, r1, bt);
    end
    for (int k = 0; k < 10 && !cur_vld(); k++) idle();
    repeat (2) step(0, 1, 0, 0, 0, 0, '0, '0, '0);
    step(1, 1, 0, 0, 0, 0, '0, '0, '0);
    repeat (6) idle();
    step(0, 0, 0, 0, 0, 1, '0, '0, '0);
    repeat (5) idle();
    step(0, 0, 1, 0, 1, 0, 32'h8, '0, 32'h400);
    repeat (3) idle();
    step(1, 0, 0, 0, 0, 0, '0, '0, '0);
    repeat (5) idle();
    @(negedge i_clk);
    #1;
    cmp("drain", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
